// File: rtl/layer3_pool_feeder.sv
// Buffers conv-layer words in a small FIFO and replays them to the pooling layer
// as fixed-length window bursts, pausing for a pooling handshake after each frame.
module layer3_pool_feeder #(
  parameter int bits          = 16,
  parameter int bits_shift    = 4,
  parameter int channel_num   = 16,
  parameter int pool_size     = 4,
  parameter int win_per_frame = 16,
  parameter int fifo_aw       = 4
) (
  input  logic                                 clk_in,
  input  logic                                 rst_n,
  input  logic [(channel_num<<bits_shift)-1:0] data_in,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [(channel_num<<bits_shift)-1:0] data_out,
  output logic                                 start,
  input  logic                                 pool_ready,
  output logic                                 frame_done
);

  localparam int LANE_W = 1 << bits_shift;
  localparam int WORD_W = channel_num << bits_shift;
  localparam int DEPTH  = 1 << fifo_aw;
  localparam int BEAT_W = $clog2(pool_size + 1);
  localparam int WIN_W  = $clog2(win_per_frame + 1);

  localparam logic [fifo_aw:0]  POOL_CNT  = (fifo_aw + 1)'(pool_size);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(pool_size);
  localparam logic [WIN_W-1:0]  LAST_WIN  = WIN_W'(win_per_frame - 1);

  typedef enum logic [1:0] {IDLE, BURST, GAP, WAIT_DONE} state_t;

  logic [WORD_W-1:0]  r_mem [DEPTH];
  logic [fifo_aw-1:0] r_wptr;
  logic [fifo_aw-1:0] r_rptr;
  logic [fifo_aw:0]   r_count;
  state_t             r_state;
  logic [BEAT_W-1:0]  r_beat;
  logic [WIN_W-1:0]   r_win;
  logic [WORD_W-1:0]  r_data_out;
  logic               r_start;
  logic               r_frame_done;

  logic               w_push;
  logic               w_pop;
  state_t             w_state_nxt;
  logic               w_start_nxt;
  logic               w_done_nxt;
  logic [BEAT_W-1:0]  w_beat_nxt;
  logic [WIN_W-1:0]   w_win_nxt;
  logic [WORD_W-1:0]  w_head;

  // count never exceeds DEPTH, so its MSB alone means "full".
  assign in_ready   = ~r_count[fifo_aw];
  assign w_push     = in_valid & in_ready;
  assign data_out   = r_data_out;
  assign start      = r_start;
  assign frame_done = r_frame_done;

  // Head word assembled lane by lane: sample field and any lane padding pass untouched.
  for (genvar i = 0; i < channel_num; i++) begin : g_lane
    assign w_head[i*LANE_W +: bits] = r_mem[r_rptr][i*LANE_W +: bits];
    if (bits < LANE_W) begin : g_pad
      assign w_head[i*LANE_W+bits +: LANE_W-bits] = r_mem[r_rptr][i*LANE_W+bits +: LANE_W-bits];
    end
  end

  // NOTE: the storage array has no reset; only pointers and count define what is valid.
  always_ff @(posedge clk_in) begin
    if (w_push) r_mem[r_wptr] <= data_in;
  end

  // NOTE: every register below uses <= so all of them see pre-edge values of each other.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_beat       <= '0;
      r_win        <= '0;
      r_data_out   <= '0;
      r_start      <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_beat       <= w_beat_nxt;
      r_win        <= w_win_nxt;
      r_start      <= w_start_nxt;
      r_frame_done <= w_done_nxt;
      if (w_pop) r_data_out <= w_head;
    end
  end

  // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_start_nxt = 1'b0;
    w_done_nxt  = 1'b0;
    w_beat_nxt  = r_beat;
    w_win_nxt   = r_win;
    unique case (r_state)
      IDLE, GAP: begin
        if (r_count >= POOL_CNT) begin
          w_state_nxt = BURST;
          w_pop       = 1'b1;
          w_start_nxt = 1'b1;
          w_beat_nxt  = BEAT_W'(1);
        end
      end
      BURST: begin
        if (r_beat != LAST_BEAT) begin
          w_pop       = 1'b1;
          w_start_nxt = 1'b1;
          w_beat_nxt  = r_beat + 1'b1;
        end else begin
          w_beat_nxt = '0;
          if (r_win == LAST_WIN) begin
            w_win_nxt   = '0;
            w_state_nxt = WAIT_DONE;
          end else begin
            w_win_nxt   = r_win + 1'b1;
            w_state_nxt = GAP;
          end
        end
      end
      WAIT_DONE: begin
        if (pool_ready) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule
